ftd_sync_fifo_responder: RTL and testbench

Synthesizable device-side responder for the FTDI 245-synchronous FIFO bus that `radioberry_phy` drives as master. It sits opposite the FPGA PHY, in a loopback bitstream or in a bench, and plays the role of the FTDI chip:
- Host-to-FPGA bytes are buffered in an RX FIFO and served on the bus.
- Bytes the PHY writes are captured into a TX FIFO and presented as an AXI-stream-style output.
- `send_immediately_n` pulses become packet boundaries (`tlast`).

---
 rtl/ftd_sync_fifo_responder.sv | 144 ++++++++++++++
 tb/tb_ftd_sync_fifo_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ftd_sync_fifo_responder.sv
// Device-side model of an FTDI 245-synchronous FIFO: buffers host bytes toward the PHY (RX)
// and captures PHY writes toward the host as a byte stream with packet boundaries (TX).
module ftd_sync_fifo_responder #(
  parameter int RX_DEPTH = 512,
  parameter int TX_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    host_rx_tdata,
  input  logic                          host_rx_tvalid,
  output logic                          host_rx_tready,
  output logic [7:0]                    host_tx_tdata,
  output logic                          host_tx_tvalid,
  output logic                          host_tx_tlast,
  input  logic                          host_tx_tready,
  output logic                          rx_fifo_empty,
  input  logic                          read_rx_fifo_n,
  input  logic                          output_enable_n,
  output logic                          tx_fifo_full,
  input  logic                          write_tx_fifo_n,
  input  logic                          send_immediately_n,
  input  logic [7:0]                    data_i,
  output logic [7:0]                    data_o,
  output logic                          data_en,
  output logic [$clog2(RX_DEPTH):0]     rx_level,
  output logic [$clog2(TX_DEPTH):0]     tx_level,
  output logic                          err_rd_empty,
  output logic                          err_wr_full,
  output logic                          err_contention,
  input  logic                          clr_err
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(TX_DEPTH);

  // ---------------- RX path: host -> PHY ----------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0] rx_wr_ptr_nxt, rx_rd_ptr_nxt, rx_level_nxt;
  logic [7:0]     rx_head_nxt;
  logic           rx_push, rx_pop;

  assign rx_level       = rx_wr_ptr - rx_rd_ptr;
  assign host_rx_tready = (rx_level < RX_FULL_LVL);
  assign rx_push        = host_rx_tvalid & host_rx_tready;
  assign rx_pop         = ~output_enable_n & ~read_rx_fifo_n & ~rx_fifo_empty;

  always_comb begin
    rx_wr_ptr_nxt = rx_wr_ptr + (RX_AW+1)'(rx_push);
    rx_rd_ptr_nxt = rx_rd_ptr + (RX_AW+1)'(rx_pop);
    rx_level_nxt  = rx_wr_ptr_nxt - rx_rd_ptr_nxt;
    // The byte written this edge is not yet in the array, so forward it when it becomes the head.
    if (rx_push && (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr_nxt[RX_AW-1:0]))
      rx_head_nxt = host_rx_tdata;
    else
      rx_head_nxt = rx_mem[rx_rd_ptr_nxt[RX_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wr_ptr[RX_AW-1:0]] <= host_rx_tdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      rx_fifo_empty <= 1'b1;
      data_o        <= '0;
      data_en       <= 1'b0;
    end else begin
      rx_wr_ptr     <= rx_wr_ptr_nxt;
      rx_rd_ptr     <= rx_rd_ptr_nxt;
      rx_fifo_empty <= (rx_level_nxt == '0);
      data_o        <= rx_head_nxt;
      data_en       <= ~output_enable_n;
    end
  end

  // ---------------- TX path: PHY -> host ----------------
  logic [7:0]          tx_mem [TX_DEPTH];
  logic [TX_DEPTH-1:0] tx_last;
  logic [TX_AW:0]      tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]      tx_wr_ptr_nxt, tx_rd_ptr_nxt, tx_level_nxt;
  logic [TX_AW-1:0]    tx_prev_idx;
  logic                tx_push, tx_pop;

  assign tx_level       = tx_wr_ptr - tx_rd_ptr;
  assign host_tx_tvalid = (tx_level != '0);
  assign host_tx_tdata  = tx_mem[tx_rd_ptr[TX_AW-1:0]];
  assign host_tx_tlast  = host_tx_tvalid & tx_last[tx_rd_ptr[TX_AW-1:0]];
  assign tx_push        = ~write_tx_fifo_n & ~tx_fifo_full;
  assign tx_pop         = host_tx_tvalid & host_tx_tready;
  assign tx_prev_idx    = tx_wr_ptr[TX_AW-1:0] - TX_AW'(1);

  always_comb begin
    tx_wr_ptr_nxt = tx_wr_ptr + (TX_AW+1)'(tx_push);
    tx_rd_ptr_nxt = tx_rd_ptr + (TX_AW+1)'(tx_pop);
    tx_level_nxt  = tx_wr_ptr_nxt - tx_rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wr_ptr[TX_AW-1:0]] <= data_i;
  end

  // A flush with no write marks the newest entry, which stays queued as long as the level is non-zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr    <= '0;
      tx_rd_ptr    <= '0;
      tx_fifo_full <= 1'b0;
      tx_last      <= '0;
    end else begin
      tx_wr_ptr    <= tx_wr_ptr_nxt;
      tx_rd_ptr    <= tx_rd_ptr_nxt;
      tx_fifo_full <= (tx_level_nxt == TX_FULL_LVL);
      if (tx_push)
        tx_last[tx_wr_ptr[TX_AW-1:0]] <= ~send_immediately_n;
      else if (~send_immediately_n && (tx_level != '0))
        tx_last[tx_prev_idx] <= 1'b1;
    end
  end

  // ---------------- sticky error flags ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_rd_empty   <= 1'b0;
      err_wr_full    <= 1'b0;
      err_contention <= 1'b0;
    end else if (clr_err) begin
      err_rd_empty   <= 1'b0;
      err_wr_full    <= 1'b0;
      err_contention <= 1'b0;
    end else begin
      if (~read_rx_fifo_n && rx_fifo_empty)  err_rd_empty   <= 1'b1;
      if (~write_tx_fifo_n && tx_fifo_full)  err_wr_full    <= 1'b1;
      if (~write_tx_fifo_n && data_en)       err_contention <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ftd_sync_fifo_responder.sv
// Scoreboard bench for ftd_sync_fifo_responder: directed stimulus queues expected bytes,
// a negedge monitor pops and compares whenever the DUT hands a byte over.
module tb_ftd_sync_fifo_responder;

  logic       clk, reset;
  logic [7:0] host_rx_tdata;
  logic       host_rx_tvalid, host_rx_tready;
  logic [7:0] host_tx_tdata;
  logic       host_tx_tvalid, host_tx_tlast, host_tx_tready;
  logic       rx_fifo_empty, read_rx_fifo_n, output_enable_n;
  logic       tx_fifo_full, write_tx_fifo_n, send_immediately_n;
  logic [7:0] data_i, data_o;
  logic       data_en;
  logic [9:0] rx_level, tx_level;
  logic       err_rd_empty, err_wr_full, err_contention, clr_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rx_exp [$];
  logic [8:0] tx_exp [$];

  ftd_sync_fifo_responder #(.RX_DEPTH(512), .TX_DEPTH(512)) dut (
    .clk(clk), .reset(reset),
    .host_rx_tdata(host_rx_tdata), .host_rx_tvalid(host_rx_tvalid), .host_rx_tready(host_rx_tready),
    .host_tx_tdata(host_tx_tdata), .host_tx_tvalid(host_tx_tvalid), .host_tx_tlast(host_tx_tlast),
    .host_tx_tready(host_tx_tready),
    .rx_fifo_empty(rx_fifo_empty), .read_rx_fifo_n(read_rx_fifo_n), .output_enable_n(output_enable_n),
    .tx_fifo_full(tx_fifo_full), .write_tx_fifo_n(write_tx_fifo_n), .send_immediately_n(send_immediately_n),
    .data_i(data_i), .data_o(data_o), .data_en(data_en),
    .rx_level(rx_level), .tx_level(tx_level),
    .err_rd_empty(err_rd_empty), .err_wr_full(err_wr_full), .err_contention(err_contention),
    .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rx_empty"}, rx_fifo_empty, 1);
    chk({tag, "_tx_full"}, tx_fifo_full, 0);
    chk({tag, "_data_en"}, data_en, 0);
    chk({tag, "_data_o"}, data_o, 0);
    chk({tag, "_tvalid"}, host_tx_tvalid, 0);
    chk({tag, "_tlast"}, host_tx_tlast, 0);
    chk({tag, "_rx_tready"}, host_rx_tready, 1);
    chk({tag, "_rx_level"}, rx_level, 0);
    chk({tag, "_tx_level"}, tx_level, 0);
    chk({tag, "_errs"}, {err_rd_empty, err_wr_full, err_contention}, 0);
  endtask

  // Monitor: compares every byte handed over on either side against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (!output_enable_n && !read_rx_fifo_n && !rx_fifo_empty) begin
        if (rx_exp.size() == 0) chk("rx_extra_byte", data_o, 9'h100);
        else chk("rx_data", data_o, rx_exp.pop_front());
      end
      if (host_tx_tvalid && host_tx_tready) begin
        if (tx_exp.size() == 0) chk("tx_extra_byte", host_tx_tdata, 9'h100);
        else begin
          logic [8:0] e;
          e = tx_exp.pop_front();
          chk("tx_data", host_tx_tdata, e[7:0]);
          chk("tx_last", host_tx_tlast, e[8]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; host_rx_tdata = '0; host_rx_tvalid = 1'b0; host_tx_tready = 1'b0;
    read_rx_fifo_n = 1'b1; output_enable_n = 1'b1; write_tx_fifo_n = 1'b1;
    send_immediately_n = 1'b1; data_i = '0; clr_err = 1'b0;
    step(3);
    chk_reset_values("por");
    reset = 1'b0;
    step(2);

    // RX stream 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      host_rx_tdata = 8'(i); host_rx_tvalid = 1'b1;
      rx_exp.push_back(8'(i));
      step();
    end
    host_rx_tvalid = 1'b0;
    chk("rx_level_16", rx_level, 16);
    output_enable_n = 1'b0;
    chk("data_en_before_edge", data_en, 0);
    step();
    chk("data_en_after_edge", data_en, 1);
    read_rx_fifo_n = 1'b0;
    step(16);
    read_rx_fifo_n = 1'b1;
    chk("rx_empty_on_16th_pop", rx_fifo_empty, 1);
    chk("rx_all_bytes_read", rx_exp.size(), 0);
    chk("rx_stream_errs", {err_rd_empty, err_wr_full, err_contention}, 0);

    // RX underrun
    read_rx_fifo_n = 1'b0;
    step();
    read_rx_fifo_n = 1'b1;
    chk("err_rd_empty_set", err_rd_empty, 1);
    chk("rx_level_after_underrun", rx_level, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("err_rd_empty_cleared", err_rd_empty, 0);
    output_enable_n = 1'b1;
    step(2);
    chk("data_en_released", data_en, 0);

    // TX flush: 0xA0..0xA3 with tlast on 0xA3
    host_tx_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_i = 8'hA0 + 8'(k); write_tx_fifo_n = 1'b0;
      send_immediately_n = (k == 3) ? 1'b0 : 1'b1;
      tx_exp.push_back({(k == 3), 8'hA0 + 8'(k)});
      step();
    end
    write_tx_fifo_n = 1'b1; send_immediately_n = 1'b1;
    step(4);
    chk("tx_flush_drained", tx_exp.size(), 0);
    chk("tx_flush_errs", {err_rd_empty, err_wr_full, err_contention}, 0);

    // TX full: 513 writes into a 512-byte FIFO
    host_tx_tready = 1'b0;
    for (int i = 0; i < 513; i++) begin
      data_i = 8'(i) ^ 8'h3C; write_tx_fifo_n = 1'b0;
      if (i < 512) tx_exp.push_back({1'b0, 8'(i) ^ 8'h3C});
      step();
      if (i == 510) chk("tx_not_full_at_511", tx_fifo_full, 0);
    end
    write_tx_fifo_n = 1'b1;
    chk("tx_full_set", tx_fifo_full, 1);
    chk("err_wr_full_set", err_wr_full, 1);
    chk("tx_level_512", tx_level, 512);
    host_tx_tready = 1'b1;
    begin
      int guard;
      guard = 0;
      while ((tx_exp.size() != 0 || host_tx_tvalid) && guard < 700) begin
        step();
        guard++;
      end
      chk("tx_drain_in_time", (guard < 700), 1);
    end
    step(2);
    chk("tx_drained_count", tx_exp.size(), 0);
    chk("tx_level_after_drain", tx_level, 0);
    chk("tx_full_after_drain", tx_fifo_full, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Contention: PHY writes while the responder drives the bus
    output_enable_n = 1'b0;
    step(2);
    chk("contention_data_en", data_en, 1);
    data_i = 8'h5C; write_tx_fifo_n = 1'b0;
    tx_exp.push_back({1'b0, 8'h5C});
    step();
    write_tx_fifo_n = 1'b1;
    chk("err_contention_set", err_contention, 1);
    step(3);
    chk("contention_byte_captured", tx_exp.size(), 0);
    output_enable_n = 1'b1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("errs_cleared", {err_rd_empty, err_wr_full, err_contention}, 0);

    // Reset mid-operation: 100 bytes in RX, 50 in TX
    host_tx_tready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      host_rx_tdata = 8'(i + 1); host_rx_tvalid = 1'b1;
      data_i = 8'(i); write_tx_fifo_n = (i < 50) ? 1'b0 : 1'b1;
      step();
    end
    host_rx_tvalid = 1'b0; write_tx_fifo_n = 1'b1;
    output_enable_n = 1'b0;
    step(2);
    chk("pre_reset_rx_level", rx_level, 100);
    chk("pre_reset_tx_level", tx_level, 50);
    chk("pre_reset_data_en", data_en, 1);
    chk("pre_reset_data_o", data_o, 8'h01);
    @(posedge clk);
    #3;
    reset = 1'b1;
    output_enable_n = 1'b1;
    #1;
    chk_reset_values("midop");
    step(2);
    reset = 1'b0;
    step(2);
    chk("post_reset_rx_level", rx_level, 0);
    chk("post_reset_tx_level", tx_level, 0);
    chk("post_reset_rx_empty", rx_fifo_empty, 1);
    chk("post_reset_tvalid", host_tx_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
